// File: rtl/host_mem_avmm_arbiter.sv
// 2:1 burst-aware Avalon-MM arbiter in front of the VTP shim: round-robin command grant,
// write bursts locked to their owner, in-order read responses routed through a source-ID FIFO.
module host_mem_avmm_arbiter #(
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 512,
    parameter int BURST_W   = 7,
    parameter int RID_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     s0_address,
    input  logic                  s0_read,
    input  logic                  s0_write,
    input  logic [BURST_W-1:0]    s0_burstcount,
    input  logic [DATA_W-1:0]     s0_writedata,
    input  logic [DATA_W/8-1:0]   s0_byteenable,
    output logic                  s0_waitrequest,
    output logic [DATA_W-1:0]     s0_readdata,
    output logic                  s0_readdatavalid,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [BURST_W-1:0]    s1_burstcount,
    input  logic [DATA_W-1:0]     s1_writedata,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    output logic                  s1_waitrequest,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,

    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [BURST_W-1:0]    m_burstcount,
    output logic [DATA_W-1:0]     m_writedata,
    output logic [DATA_W/8-1:0]   m_byteenable,
    input  logic                  m_waitrequest,
    input  logic [DATA_W-1:0]     m_readdata,
    input  logic                  m_readdatavalid
);

    localparam int PTR_W  = $clog2(RID_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FIFO_W = 1 + BURST_W;

    typedef enum logic {ARB, WLOCK} state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               rr_q, rr_d;
    logic [BURST_W-1:0] rem_q, rem_d;

    logic [FIFO_W-1:0]  fifo_mem_q [RID_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] beat_q, beat_d;

    logic               rdv0_q, rdv0_d;
    logic               rdv1_q, rdv1_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               fifo_full, fifo_empty;
    logic               elig0, elig1;
    logic               gnt;
    logic               sel_read, sel_write;
    logic               gnt_wait;
    logic               acc_rd, acc_wr;
    logic               push, pop, rsp_ok, last_beat;
    logic [FIFO_W-1:0]  head;
    logic               head_src;
    logic [BURST_W-1:0] head_bc;

    assign fifo_full  = (cnt_q == CNT_W'(RID_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    // A read facing a full ID FIFO is not a candidate, so it cannot starve the other side.
    assign elig0 = (s0_read | s0_write) & ~(s0_read & fifo_full);
    assign elig1 = (s1_read | s1_write) & ~(s1_read & fifo_full);

    always_comb begin
        gnt = rr_q;
        if (state_q == WLOCK)       gnt = owner_q;
        else if (elig0 && !elig1)   gnt = 1'b0;
        else if (elig1 && !elig0)   gnt = 1'b1;
    end

    always_comb begin
        sel_read     = gnt ? s1_read       : s0_read;
        sel_write    = gnt ? s1_write      : s0_write;
        m_address    = gnt ? s1_address    : s0_address;
        m_burstcount = gnt ? s1_burstcount : s0_burstcount;
        m_writedata  = gnt ? s1_writedata  : s0_writedata;
        m_byteenable = gnt ? s1_byteenable : s0_byteenable;
        m_read         = 1'b0;
        m_write        = 1'b0;
        gnt_wait       = 1'b1;
        s0_waitrequest = 1'b1;
        s1_waitrequest = 1'b1;
        if (reset_n) begin
            if (state_q == WLOCK) begin
                m_write  = sel_write;
                gnt_wait = m_waitrequest | sel_read;
            end else begin
                m_read   = sel_read & ~fifo_full;
                m_write  = sel_write;
                gnt_wait = m_waitrequest | (sel_read & fifo_full);
            end
            if (gnt) s1_waitrequest = gnt_wait;
            else     s0_waitrequest = gnt_wait;
        end
    end

    assign acc_rd = m_read  & ~m_waitrequest;
    assign acc_wr = m_write & ~m_waitrequest;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        case (state_q)
            ARB: begin
                if (acc_rd) begin
                    rr_d = ~gnt;
                end else if (acc_wr) begin
                    if (m_burstcount > BURST_W'(1)) begin
                        state_d = WLOCK;
                        owner_d = gnt;
                        rem_d   = m_burstcount - BURST_W'(1);
                    end else begin
                        rr_d = ~gnt;
                    end
                end
            end
            WLOCK: begin
                if (acc_wr) begin
                    rem_d = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) begin
                        state_d = ARB;
                        rr_d    = ~owner_q;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Response side: head of the ID FIFO names the requester; pop on its final beat.
    assign head      = fifo_mem_q[rd_ptr_q];
    assign head_src  = head[BURST_W];
    assign head_bc   = head[BURST_W-1:0];
    assign push      = acc_rd;
    assign rsp_ok    = m_readdatavalid & ~fifo_empty;
    assign last_beat = rsp_ok & ((beat_q + BURST_W'(1)) == head_bc);
    assign pop       = last_beat;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        beat_d   = beat_q;
        if (rsp_ok) beat_d = last_beat ? '0 : beat_q + BURST_W'(1);
        rdv0_d   = rsp_ok & ~head_src;
        rdv1_d   = rsp_ok &  head_src;
        rdata_d  = m_readdatavalid ? m_readdata : rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            rem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            rdv0_q   <= 1'b0;
            rdv1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            rdv0_q   <= rdv0_d;
            rdv1_q   <= rdv1_d;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (push) fifo_mem_q[wr_ptr_q] <= {gnt, m_burstcount};
    end

    assign s0_readdata      = rdata_q;
    assign s1_readdata      = rdata_q;
    assign s0_readdatavalid = rdv0_q;
    assign s1_readdatavalid = rdv1_q;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(m_readdatavalid && fifo_empty))
                else $error("host_mem_avmm_arbiter: readdatavalid with no outstanding read");
            assert (!((acc_rd || (acc_wr && state_q == ARB)) && m_burstcount == '0))
                else $error("host_mem_avmm_arbiter: burstcount of zero accepted");
        end
    end

endmodule
